comp_sweep_checker: RTL and testbench

Synthesizable stimulus generator and self-checker for the `WIDTH`-bit magnitude comparator: the driving end of the comparator's a/b → e/l/g interface. On `start` it sweeps every (a, b) pair exhaustively, waits a programmable settle time, and samples e/l/g against an internally computed expectation. It reports an error count, the first failing vector and a pass flag, and sits beside the comparator for on-board or in-simulation bring-up.

---
 rtl/comp_sweep_checker_if.sv | 14 +
 rtl/comp_sweep_checker.sv | 149 ++++++++++++++
 tb/tb_comp_sweep_checker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/comp_sweep_checker_if.sv
// Operand/result bus between the sweep checker (master) and the magnitude
// comparator under test (slave).
interface comp_sweep_checker_if #(
  parameter int unsigned WIDTH = 2
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e;
  logic             l;
  logic             g;

  modport master (output a, output b, input e, input l, input g);
  modport slave  (input a, input b, output e, output l, output g);
endinterface

// File: rtl/comp_sweep_checker.sv
// Exhaustive stimulus generator and self-checker for a WIDTH-bit magnitude
// comparator: drives every (a, b) pair, waits SETTLE cycles, checks e/l/g.
module comp_sweep_checker #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  comp_sweep_checker_if.master cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_a,
  output logic [WIDTH-1:0]     first_err_b
);

  localparam int unsigned IDX_W = 2 * WIDTH;
  localparam int unsigned ERR_W = 2 * WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);

  // The sampling step is folded into the last WAIT edge, so no CHECK state.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [ERR_W-1:0] err_q,       err_d;
  logic             fev_q,       fev_d;
  logic [WIDTH-1:0] fea_q,       fea_d;
  logic [WIDTH-1:0] feb_q,       feb_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;

  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic [2:0]       exp_elg;
  logic [2:0]       obs_elg;
  logic             mismatch;

  assign cur_a    = idx_q[IDX_W-1:WIDTH];
  assign cur_b    = idx_q[WIDTH-1:0];
  assign exp_elg  = {cur_a == cur_b, cur_a < cur_b, cur_a > cur_b};
  assign obs_elg  = {cmp.e, cmp.l, cmp.g};
  assign mismatch = (obs_elg != exp_elg);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    feb_d   = feb_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          feb_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q != CNT_W'(SETTLE)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          if (mismatch) begin
            err_d = err_q + ERR_W'(1);
            if (!fev_q) begin
              fev_d = 1'b1;
              fea_d = cur_a;
              feb_d = cur_b;
            end
          end
          // Terminate on the last index so idx never wraps.
          if (idx_q == {IDX_W{1'b1}}) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      feb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      feb_q   <= feb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign cmp.a           = cur_a;
  assign cmp.b           = cur_b;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_a     = fea_q;
  assign first_err_b     = feb_q;

endmodule

// File: tb/tb_comp_sweep_checker.sv
// Directed bench: behavioural comparator with selectable faults drives the
// default checker; a second SETTLE=3 instance checks the stretched timing.
module tb_comp_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, rst3, start3;
  logic [1:0] mode;  // 0 correct, 1 e stuck at 0, 2 l/g swapped

  logic       busy, done, pass, fev;
  logic [4:0] err_count;
  logic [1:0] fea, feb;
  logic       busy3, done3, pass3, fev3;
  logic [4:0] err_count3;
  logic [1:0] fea3, feb3;

  comp_sweep_checker_if #(.WIDTH(2)) bus1 ();
  comp_sweep_checker_if #(.WIDTH(2)) bus3 ();

  assign bus1.e = (mode == 2'd1) ? 1'b0 : (bus1.a == bus1.b);
  assign bus1.l = (mode == 2'd2) ? (bus1.a > bus1.b) : (bus1.a < bus1.b);
  assign bus1.g = (mode == 2'd2) ? (bus1.a < bus1.b) : (bus1.a > bus1.b);

  assign bus3.e = (bus3.a == bus3.b);
  assign bus3.l = (bus3.a < bus3.b);
  assign bus3.g = (bus3.a > bus3.b);

  comp_sweep_checker #(.WIDTH(2), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cmp(bus1),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(fev), .first_err_a(fea), .first_err_b(feb)
  );

  comp_sweep_checker #(.WIDTH(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst3), .start(start3), .cmp(bus3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
    .first_err_valid(fev3), .first_err_a(fea3), .first_err_b(feb3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".pass"}, 32'(pass), 32'd0);
    check({tag, ".err"},  32'(err_count), 32'd0);
    check({tag, ".fev"},  32'(fev), 32'd0);
    check({tag, ".fea"},  32'(fea), 32'd0);
    check({tag, ".feb"},  32'(feb), 32'd0);
    check({tag, ".ab"},   32'({bus1.a, bus1.b}), 32'd0);
  endtask

  // Full sweep from t0 to t0+32 with the comparator in fault mode m.
  task automatic run_sweep(input string tag, input logic [1:0] m, input int exp_err,
                           input int exp_fev, input int exp_fa, input int exp_fb);
    mode  = m;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check({tag, ".t0.busy"}, 32'(busy), 32'd1);
    check({tag, ".t0.done"}, 32'(done), 32'd0);
    check({tag, ".t0.err"},  32'(err_count), 32'd0);
    check({tag, ".t0.fev"},  32'(fev), 32'd0);
    check({tag, ".t0.ab"},   32'({bus1.a, bus1.b}), 32'd0);
    tick(1);
    check({tag, ".t1.ab"},   32'({bus1.a, bus1.b}), 32'd0);
    tick(1);
    check({tag, ".t2.ab"},   32'({bus1.a, bus1.b}), 32'd1);
    check({tag, ".t2.err"},  32'(err_count), (m == 2'd1) ? 32'd1 : 32'd0);
    tick(29);
    check({tag, ".t31.done"}, 32'(done), 32'd0);
    check({tag, ".t31.busy"}, 32'(busy), 32'd1);
    tick(1);
    check({tag, ".t32.done"}, 32'(done), 32'd1);
    check({tag, ".t32.busy"}, 32'(busy), 32'd0);
    check({tag, ".t32.err"},  32'(err_count), 32'(exp_err));
    check({tag, ".t32.pass"}, 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, ".t32.fev"},  32'(fev), 32'(exp_fev));
    check({tag, ".t32.fea"},  32'(fea), 32'(exp_fa));
    check({tag, ".t32.feb"},  32'(feb), 32'(exp_fb));
    check({tag, ".t32.ab"},   32'({bus1.a, bus1.b}), 32'd15);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rst3 = 1'b1; start3 = 1'b0; mode = 2'd0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0; rst3 = 1'b0;
    tick(3);
    check_all_zero("idle");

    run_sweep("good",    2'd0, 0,  0, 0, 0);
    run_sweep("e_stuck", 2'd1, 4,  1, 0, 0);
    run_sweep("b2b",     2'd0, 0,  0, 0, 0);
    run_sweep("swap",    2'd2, 12, 1, 0, 1);

    // Extra start pulses mid-sweep must be ignored.
    mode  = 2'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ign5.ab",   32'({bus1.a, bus1.b}), 32'd2);
    check("ign5.busy", 32'(busy), 32'd1);
    tick(14);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("ign20.ab",  32'({bus1.a, bus1.b}), 32'd10);
    tick(11);
    check("ign31.done", 32'(done), 32'd0);
    tick(1);
    check("ign32.done", 32'(done), 32'd1);
    check("ign32.pass", 32'(pass), 32'd1);

    // Reset mid-sweep with errors already accumulated.
    mode  = 2'd2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    check("pre_rst.err", 32'(err_count), 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all_zero("mid_rst");
    tick(3);
    check_all_zero("post_rst");
    run_sweep("after_rst", 2'd0, 0, 0, 0, 0);

    // SETTLE=3: four cycles per vector, done at t0+64.
    start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    check("s3.t0.ab", 32'({bus3.a, bus3.b}), 32'd0);
    check("s3.t0.busy", 32'(busy3), 32'd1);
    tick(3);
    check("s3.t3.ab", 32'({bus3.a, bus3.b}), 32'd0);
    tick(1);
    check("s3.t4.ab", 32'({bus3.a, bus3.b}), 32'd1);
    tick(4);
    check("s3.t8.ab", 32'({bus3.a, bus3.b}), 32'd2);
    tick(55);
    check("s3.t63.done", 32'(done3), 32'd0);
    tick(1);
    check("s3.t64.done", 32'(done3), 32'd1);
    check("s3.t64.pass", 32'(pass3), 32'd1);
    check("s3.t64.err",  32'(err_count3), 32'd0);
    check("s3.t64.fev",  32'(fev3), 32'd0);
    check("s3.t64.fe",   32'({fea3, feb3}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
